// File: rtl/tpu_stream_pkg.sv
// Shared types and constants for the MLP result byte streamer.
// Optional checksum byte controlled by macro RESULT_CHECKSUM_EN.
package tpu_stream_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN_BASE = 10;

`ifdef RESULT_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

    // Byte index width; covers up to 16 bytes per frame.
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_state_t;

    typedef struct packed {
        logic [2:0]         layer;
        logic signed [31:0] acc0;
        logic signed [31:0] acc1;
    } result_entry_t;

    // Byte at position idx of the base frame (header, layer, acc0, acc1; MSB first).
    function automatic logic [7:0] frame_byte(input result_entry_t e,
                                              input logic [7:0]    hdr,
                                              input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = hdr;
            4'd1:    b = {5'b0, e.layer};
            4'd2:    b = e.acc0[31:24];
            4'd3:    b = e.acc0[23:16];
            4'd4:    b = e.acc0[15:8];
            4'd5:    b = e.acc0[7:0];
            4'd6:    b = e.acc1[31:24];
            4'd7:    b = e.acc1[23:16];
            4'd8:    b = e.acc1[15:8];
            4'd9:    b = e.acc1[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef RESULT_CHECKSUM_EN
    // XOR over every base-frame byte, header included.
    function automatic logic [7:0] frame_checksum(input result_entry_t e,
                                                  input logic [7:0]    hdr);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < FRAME_LEN_BASE; i++) begin
            x = x ^ frame_byte(e, hdr, IDX_W'(i));
        end
        return x;
    endfunction
`endif

endpackage

// File: rtl/mlp_result_streamer_if.sv
// Valid/ready byte stream from the result streamer towards the UART transmitter.
interface mlp_result_streamer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/result_fifo.sv
// Synchronous show-ahead FIFO of result entries; the head is readable while not empty.
// Full/empty come from the occupancy counter, pointers wrap modulo DEPTH.
module result_fifo
    import tpu_stream_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = result_entry_t,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    entry_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mlp_result_streamer.sv
// Buffers MLP result pairs and serializes each into a fixed byte frame for the UART.
// Define RESULT_CHECKSUM_EN to append an XOR checksum byte to every frame.
module mlp_result_streamer
    import tpu_stream_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       acc_valid,
    input  logic signed [31:0]         acc0,
    input  logic signed [31:0]         acc1,
    input  logic [2:0]                 layer,
    input  logic                       clr_overflow,
    mlp_result_streamer_if.master      tx,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    stream_state_t    state_q, state_d;
    result_entry_t    frame_q, frame_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             overflow_q, overflow_d;
`ifdef RESULT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    result_entry_t    acc_entry, head;
    logic             fifo_pop, fifo_full, fifo_empty, drop;
    logic [IDX_W-1:0] next_idx;
    logic [7:0]       next_byte;

    assign acc_entry = '{layer: layer, acc0: acc0, acc1: acc1};

    result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (result_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (acc_valid),
        .push_data (acc_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign drop = acc_valid && fifo_full && !fifo_pop;

    always_comb begin
        next_idx  = idx_q + IDX_W'(1);
        next_byte = frame_byte(frame_q, HEADER, next_idx);
`ifdef RESULT_CHECKSUM_EN
        if (next_idx == IDX_W'(FRAME_LEN_BASE)) begin
            next_byte = csum_q;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        fifo_pop   = 1'b0;
`ifdef RESULT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    frame_d    = head;
                    idx_d      = '0;
                    state_d    = SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HEADER;
`ifdef RESULT_CHECKSUM_EN
                    csum_d     = frame_checksum(head, HEADER);
`endif
                end
            end
            SEND: begin
                if (tx_valid_q && tx.tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Reload straight from the FIFO so frames run back-to-back.
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            frame_d    = head;
                            idx_d      = '0;
                            tx_valid_d = 1'b1;
                            tx_data_d  = HEADER;
`ifdef RESULT_CHECKSUM_EN
                            csum_d     = frame_checksum(head, HEADER);
`endif
                        end else begin
                            state_d    = IDLE;
                            idx_d      = '0;
                            tx_valid_d = 1'b0;
                            tx_data_d  = 8'h00;
                        end
                    end else begin
                        idx_d     = next_idx;
                        tx_data_d = next_byte;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    // A drop wins over a simultaneous clear so no loss goes unreported.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
`ifdef RESULT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q == SEND) || (fifo_count != '0);

endmodule

// File: tb/tb_mlp_result_streamer.sv
// Self-checking bench for mlp_result_streamer: vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_mlp_result_streamer;

    localparam int DEPTH = 4;
`ifdef RESULT_CHECKSUM_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               acc_valid;
    logic signed [31:0] acc0;
    logic signed [31:0] acc1;
    logic [2:0]         layer;
    logic               clr_overflow;
    logic               tx_ready;
    logic               overflow;
    logic [2:0]         fifo_count;
    logic               busy;
    logic               tx_valid;
    logic [7:0]         tx_data;

    mlp_result_streamer_if tx_if();
    assign tx_if.tx_ready = tx_ready;
    assign tx_valid       = tx_if.tx_valid;
    assign tx_data        = tx_if.tx_data;

    mlp_result_streamer #(.DEPTH(DEPTH), .HEADER(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .acc_valid    (acc_valid),
        .acc0         (acc0),
        .acc1         (acc1),
        .layer        (layer),
        .clr_overflow (clr_overflow),
        .tx           (tx_if.master),
        .overflow     (overflow),
        .fifo_count   (fifo_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];
    int         ready_mode = 2;   // 0: always ready, 1: pattern 1,0,0,1, 2: never, 3: manual
    bit         mon_en     = 1'b0;

    typedef struct packed {
        logic [2:0]  layer;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  mode;
        logic [87:0] frame;   // expected bytes, first byte in the top octet, checksum last
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_model(input logic [2:0] l, input logic [31:0] a0, input logic [31:0] a1);
        logic [7:0] f[11];
        logic [7:0] x;
        f[0] = 8'hA5;          f[1] = {5'b0, l};
        f[2] = a0[31:24];      f[3] = a0[23:16];  f[4] = a0[15:8];  f[5] = a0[7:0];
        f[6] = a1[31:24];      f[7] = a1[23:16];  f[8] = a1[15:8];  f[9] = a1[7:0];
        x = 8'h00;
        for (int i = 0; i < 10; i++) x = x ^ f[i];
        f[10] = x;
        for (int i = 0; i < FL; i++) exp_q.push_back(f[i]);
    endtask

    task automatic pulse(input logic [2:0] l, input logic [31:0] a0, input logic [31:0] a1,
                         input bit model, input bit clr);
        layer = l; acc0 = a0; acc1 = a1; acc_valid = 1'b1; clr_overflow = clr;
        if (model) push_model(l, a0, a1);
        @(posedge clk); #1;
        acc_valid = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        compared++;
        if (n >= max_cyc) begin
            mismatched++;
            $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
        check({name, "_valid_idle"}, {31'b0, tx_valid}, 32'd0);
    endtask

    // Ready generator
    initial begin
        int rcyc;
        rcyc = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
                2:       tx_ready = 1'b0;
                default: ;
            endcase
            rcyc++;
        end
    end

    // Byte monitor: scoreboard compare, stall stability, no mid-frame valid drop
    initial begin
        int         pos;
        bit         prev_v, prev_r;
        logic [7:0] prev_d, exp_b;
        pos = 0; prev_v = 0; prev_r = 0; prev_d = 8'h00;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                pos = 0; prev_v = 0; prev_r = 0;
            end else begin
                if (prev_v && !prev_r)
                    check("stall_hold", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, prev_d});
                if (pos != 0)
                    check("valid_mid_frame", {31'b0, tx_valid}, 32'd1);
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_byte: got 0x%02h, required no byte", tx_data);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("tx_byte", {24'b0, tx_data}, {24'b0, exp_b});
                        $display("byte pos=%0d data=0x%02h expect=0x%02h", pos, tx_data, exp_b);
                    end
                    pos = (pos == FL - 1) ? 0 : pos + 1;
                end
                prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int peak, run, hs, n, seen;
        bit started, ended;
        logic [31:0] r0, r1;

        tbl[0] = '{layer: 3'd2, a0: 32'h0000_0102, a1: 32'hFFFF_FFFF, mode: 2'd0,
                   frame: 88'hA5_02_00_00_01_02_FF_FF_FF_FF_A4};
        tbl[1] = '{layer: 3'd2, a0: 32'h0000_0102, a1: 32'hFFFF_FFFF, mode: 2'd1,
                   frame: 88'hA5_02_00_00_01_02_FF_FF_FF_FF_A4};
        tbl[2] = '{layer: 3'd7, a0: 32'h8000_0000, a1: 32'h7FFF_FFFF, mode: 2'd0,
                   frame: 88'hA5_07_80_00_00_00_7F_FF_FF_FF_A2};
        tbl[3] = '{layer: 3'd0, a0: 32'h1234_5678, a1: 32'hDEAD_BEEF, mode: 2'd1,
                   frame: 88'hA5_00_12_34_56_78_DE_AD_BE_EF_8F};
        tbl[4] = '{layer: 3'd5, a0: 32'hFFFF_FFFE, a1: 32'h0000_0001, mode: 2'd1,
                   frame: 88'hA5_05_FF_FF_FF_FE_00_00_00_01_A0};

        rst = 1'b1; acc_valid = 1'b0; acc0 = '0; acc1 = '0; layer = '0; clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("reset_tx_data", {24'b0, tx_data}, 32'd0);
        check("reset_overflow", {31'b0, overflow}, 32'd0);
        check("reset_fifo_count", {29'b0, fifo_count}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single frames, free-running and backpressured
        for (int v = 0; v < 5; v++) begin
            ready_mode = int'(tbl[v].mode);
            for (int b = 0; b < FL; b++) exp_q.push_back(tbl[v].frame[87 - 8*b -: 8]);
            pulse(tbl[v].layer, tbl[v].a0, tbl[v].a1, 1'b0, 1'b0);
            check("latency_n1_valid", {31'b0, tx_valid}, 32'd0);
            @(posedge clk); #1;
            check("latency_n2_valid", {31'b0, tx_valid}, 32'd1);
            check("latency_n2_header", {24'b0, tx_data}, 32'h0000_00A5);
            wait_idle("single", 200);
        end

        // Burst of four back-to-back results
        ready_mode = 0;
        @(posedge clk); #1;
        peak = 0; run = 0; started = 0; ended = 0;
        for (int k = 0; k < 80; k++) begin
            if (k < 4) begin
                r0 = $urandom; r1 = $urandom;
                layer = 3'(k + 1); acc0 = r0; acc1 = r1; acc_valid = 1'b1;
                push_model(3'(k + 1), r0, r1);
            end else begin
                acc_valid = 1'b0;
            end
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (tx_valid) begin
                started = 1;
                if (!ended) run++;
            end else if (started) begin
                ended = 1;
            end
            @(posedge clk); #1;
        end
        acc_valid = 1'b0;
        check("burst_peak_count", peak, 32'd3);
        check("burst_contiguous_bytes", run, 4 * FL);
        check("burst_overflow", {31'b0, overflow}, 32'd0);
        wait_idle("burst", 100);

        // Overflow: one frame stalled in SEND, four buffered, later pulses dropped
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) pulse(3'(k), 32'h1000_0000 + k, 32'h2000_0000 - k, 1'b1, 1'b0);
        check("ovf_count_full", {29'b0, fifo_count}, 32'd4);
        check("ovf_not_yet", {31'b0, overflow}, 32'd0);
        pulse(3'd6, 32'hDEAD_0006, 32'hBEEF_0006, 1'b0, 1'b0);
        check("ovf_count_after_drop", {29'b0, fifo_count}, 32'd4);
        check("ovf_set", {31'b0, overflow}, 32'd1);
        pulse(3'd7, 32'hDEAD_0007, 32'hBEEF_0007, 1'b0, 1'b1);
        check("ovf_drop_beats_clear", {31'b0, overflow}, 32'd1);
        ready_mode = 0;
        wait_idle("ovf_drain", 200);
        check("ovf_sticky", {31'b0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        check("ovf_cleared", {31'b0, overflow}, 32'd0);

        // Reset in the middle of a frame with two entries buffered
        mon_en = 1'b0;
        exp_q.delete();
        ready_mode = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) pulse(3'(k), 32'hA0A0_0000 + k, 32'h0B0B_0000 + k, 1'b0, 1'b0);
        hs = 0; n = 0;
        while (hs < 4 && n < 50) begin
            @(negedge clk);
            if (tx_valid && tx_ready) hs++;
            n++;
        end
        check("rstmid_bytes_before", hs, 32'd4);
        check("rstmid_count_before", {29'b0, fifo_count}, 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rstmid_fifo_count", {29'b0, fifo_count}, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_valid) seen++;
        end
        check("rstmid_no_trailing", seen, 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Push into a full FIFO on the cycle the last byte handshakes
        ready_mode = 3;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) pulse(3'(k + 2), 32'h5500_0000 + k, 32'h00AA_0000 + k, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("pushfull_count_before", {29'b0, fifo_count}, 32'd4);
        for (int i = 0; i < FL; i++) begin
            tx_ready = 1'b1;
            if (i == FL - 1) begin
                layer = 3'd1; acc0 = 32'hCAFE_F00D; acc1 = 32'h0123_4567; acc_valid = 1'b1;
                push_model(3'd1, 32'hCAFE_F00D, 32'h0123_4567);
            end
            @(posedge clk); #1;
        end
        acc_valid = 1'b0;
        tx_ready  = 1'b0;
        check("pushfull_count_after", {29'b0, fifo_count}, 32'd4);
        check("pushfull_overflow", {31'b0, overflow}, 32'd0);
        ready_mode = 0;
        wait_idle("pushfull_drain", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mlp_result_streamer.md
# mlp_result_streamer

Downstream stage of the MLP datapath: captures each `acc0`/`acc1` result pair when `acc_valid` pulses and buffers it in a small FIFO. Each buffered pair is serialized into a fixed byte frame on a valid/ready byte interface that feeds the UART transmitter. The block decouples MLP result bursts from the slow UART byte rate and reports overflow when results arrive faster than they drain.

## Interface
- `DEPTH`, default 4: result-pair FIFO entries. Power of two, ≥2.
- `HEADER`, default 8'hA5: first byte of every frame.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `acc_valid` in 1: one-cycle pulse; the result pair is valid this cycle.
- `acc0` in 32, signed: column-0 accumulator.
- `acc1` in 32, signed: column-1 accumulator.
- `layer` in 3: `current_layer`, sampled with `acc_valid`.
- `clr_overflow` in 1: clears the sticky `overflow` flag.
- `tx_data` out 8: frame byte.
- `tx_valid` out 1: `tx_data` holds a byte.
- `tx_ready` in 1: the consumer accepts the byte.
- `overflow` out 1: sticky; a result was dropped.
- `fifo_count` out $clog2(DEPTH+1): occupied entries.
- `busy` out 1: frame in progress or FIFO non-empty.

## Operation
- **Entry format:** {layer[2:0], acc0[31:0], acc1[31:0]}, 67 bits.
- **Push:** an entry is pushed on `acc_valid` if `fifo_count<DEPTH`, or if a pop happens in the same cycle.
- **Drop on full:** otherwise the entry is dropped and `overflow` is set.
- **Overflow priority:** `clr_overflow` and a drop in the same cycle leave `overflow`=1.
- **Frame, MSB first:**
  - `HEADER`
  - {5'b0, layer}
  - acc0[31:24], acc0[23:16], acc0[15:8], acc0[7:0]
  - acc1[31:24], acc1[23:16], acc1[15:8], acc1[7:0]
  - The checksum byte (see Configuration) follows.
- **FSM states:** IDLE, SEND.
- **IDLE:**
  - `tx_valid`=0.
  - If the FIFO is non-empty, pop the head into the frame register, set byte index=0 and go to SEND.
- **SEND:**
  - `tx_valid`=1 and `tx_data`=frame[index].
  - On `tx_valid&&tx_ready`, increment the index.
  - On the handshake of the last byte: if the FIFO is non-empty, pop and reload the frame register, set index=0 and stay in SEND (back-to-back frames, no gap). Otherwise return to IDLE.
- **Handshake rules:**
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` stays stable and `tx_valid` stays high.
  - `tx_valid` never drops mid-frame.
- `fifo_count` = pushes − pops. It is never negative and never exceeds DEPTH.
- `busy` = (state==SEND) || (`fifo_count`!=0).

## Timing
- **Reset values:** state=IDLE, `tx_valid`=0, `tx_data`=8'h00, `overflow`=0, `fifo_count`=0, `busy`=0. FIFO pointers and byte index=0.
- **Reset mid-frame:** the partial frame and all FIFO contents are discarded. No trailing bytes are emitted.
- **Latency:**
  - `acc_valid` in cycle N → entry written at end of N.
  - IDLE pops at end of N+1.
  - `tx_valid`=1 with `HEADER` in N+2.
- **Throughput:** with `tx_ready` held at 1, one byte per cycle, frames back-to-back.
- **Full FIFO:** `acc_valid` in the same cycle as a last-byte handshake that pops is accepted. `fifo_count` is unchanged.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH. Full/empty are derived from `fifo_count`.

## Configuration
- Macro: `RESULT_CHECKSUM_EN`.
- **Defined:**
  - An 11th byte is appended: XOR of all ten preceding bytes, including `HEADER`.
  - The checksum is computed at frame load and stored with the frame.
- **Undefined:** frames are 10 bytes, and no checksum logic is present.

## Structure
- **Package `tpu_stream_pkg`:**
  - `HEADER` default constant.
  - `FRAME_LEN_BASE`=10.
  - `stream_state_t` enum (IDLE, SEND).
  - `result_entry_t` packed struct {layer, acc0, acc1}.
- **Sub-module `result_fifo`:**
  - Synchronous FIFO, parameterized by DEPTH and entry type.
  - Ports: push/pop/full/empty/count.
  - Pointer arithmetic stays isolated in this sub-module.

## Test plan
- **Single result:** reset; layer=2, acc0=32'h0000_0102, acc1=32'hFFFF_FFFF, `tx_ready`=1.
  - Expect `tx_valid` rising 2 cycles after `acc_valid`.
  - Bytes A5 02 00 00 01 02 FF FF FF FF.
  - Plus A4 when `RESULT_CHECKSUM_EN` is defined.
  - Then `busy`=0.
- **Backpressure:** same stimulus with `tx_ready` toggling 1,0,0,1,…
  - Identical byte sequence.
  - `tx_data` stable during every stall.
  - `tx_valid` never drops mid-frame.
- **Burst:** 4 consecutive `acc_valid` pulses, `tx_ready`=1.
  - `fifo_count` peaks at 3.
  - Four frames back-to-back with no idle cycle between them.
  - `overflow`=0.
- **Overflow:** `tx_ready`=0, 6 `acc_valid` pulses with DEPTH=4.
  - Expect `fifo_count`=4 and `overflow`=1.
  - After releasing `tx_ready`, 5 frames are emitted (1 in SEND + 4 buffered), in order.
  - `clr_overflow` then clears the flag.
- **Reset mid-frame:** assert `rst` after byte 4 of a frame, with 2 entries buffered.
  - Next cycle: `tx_valid`=0, `fifo_count`=0, `busy`=0.
  - No further bytes until a new `acc_valid`.
- **Push on full:** full FIFO; `acc_valid` coincides with a last-byte handshake.
  - Entry accepted, `fifo_count` stays 4, `overflow` stays 0.
